stack_unit: RTL and testbench

- Operand stack for the multi-cycle stack CPU; responder to the controller's push/pop/tos command strobes.
- Holds DEPTH words and presents the popped or peeked word on a registered output one cycle after the command. The datapath latches that word into A/B.
- Push data (memory read data or ALU result, selected upstream by MtoS) enters on d_in.
- Reports empty/full, occupancy, and sticky overflow/underflow errors for debug.

---
 rtl/stack_unit.sv | 145 ++++++++++++++
 tb/tb_stack_unit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/stack_unit.sv
// ---------------------------------------------------------------------------
// stack_unit -- operand stack for the multi-cycle stack CPU.
//
// Holds DEPTH words. The controller issues push/pop/tos strobes; a popped or
// peeked word is presented on the registered d_out one cycle after the
// command, with rd_valid pulsing when the read hit a real entry. Sticky
// overflow/underflow flags record illegal accesses for debug.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-low reset (0 = reset)
//   push      write d_in as the new top of stack
//   pop       remove top; its value appears on d_out next cycle
//   tos       peek top without removal; value on d_out next cycle
//   d_in      data to push
//   err_clr   synchronous clear of overflow/underflow
//   d_out     registered top-of-stack read data
//   rd_valid  one-cycle pulse: d_out was updated by a successful pop/tos
//   empty     count == 0
//   full      count == DEPTH
//   count     current number of entries, 0..DEPTH
//   overflow  sticky: push attempted while full without a pop
//   underflow sticky: pop/tos attempted while empty
// ---------------------------------------------------------------------------
module stack_unit #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int PTR_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              tos,
    input  logic [DATA_W-1:0] d_in,
    input  logic              err_clr,
    output logic [DATA_W-1:0] d_out,
    output logic              rd_valid,
    output logic              empty,
    output logic              full,
    output logic [PTR_W:0]    count,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0] ONE      = (PTR_W + 1)'(1);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [PTR_W:0]    count_q,     count_d;
    logic [DATA_W-1:0] d_out_q,     d_out_d;
    logic              rd_valid_q,  rd_valid_d;
    logic              overflow_q,  overflow_d;
    logic              underflow_q, underflow_d;

    logic              mem_we;
    logic [PTR_W-1:0]  mem_waddr;
    logic [PTR_W:0]    top_ptr;
    logic              is_empty;
    logic              is_full;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == FULL_CNT);
    // Only dereferenced when non-empty, so the low PTR_W bits always index a
    // valid entry.
    assign top_ptr  = count_q - ONE;

    // NOTE: every signal assigned here gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        count_d     = count_q;
        d_out_d     = d_out_q;
        rd_valid_d  = 1'b0;
        // err_clr only lowers a flag; a violation below re-sets it, so set wins.
        overflow_d  = overflow_q  & ~err_clr;
        underflow_d = underflow_q & ~err_clr;
        mem_we      = 1'b0;
        mem_waddr   = count_q[PTR_W-1:0];

        // Read side: pop and tos behave the same towards d_out.
        if (pop || tos) begin
            if (!is_empty) begin
                d_out_d    = mem[top_ptr[PTR_W-1:0]];
                rd_valid_d = 1'b1;
            end else begin
                d_out_d     = '0;
                underflow_d = 1'b1;
            end
        end

        // Write / pointer side.
        if (push && pop && !is_empty) begin
            // Replace top in place; legal even when full.
            mem_we    = 1'b1;
            mem_waddr = top_ptr[PTR_W-1:0];
        end else if (push) begin
            // Plain push, push+tos, or push+pop on an empty stack.
            if (!is_full) begin
                mem_we  = 1'b1;
                count_d = count_q + ONE;
            end else begin
                overflow_d = 1'b1;
            end
        end else if (pop && !is_empty) begin
            count_d = top_ptr;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q     <= '0;
            d_out_q     <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            d_out_q     <= d_out_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // NOTE: the storage array has no reset; entries are only read below the
    // pointer, so their power-up contents never reach d_out, and leaving out
    // the reset lets the array map onto plain RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= d_in;
        end
    end

    assign d_out     = d_out_q;
    assign rd_valid  = rd_valid_q;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
    assign empty     = is_empty;
    assign full      = is_full;

endmodule

// File: tb/tb_stack_unit.sv
// ---------------------------------------------------------------------------
// tb_stack_unit -- directed self-checking bench for stack_unit.
// Inputs change 1 time unit after the rising edge; outputs are checked there
// too, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_stack_unit;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int PTR_W  = 4;

    logic              clk;
    logic              rst;
    logic              push;
    logic              pop;
    logic              tos;
    logic [DATA_W-1:0] d_in;
    logic              err_clr;
    logic [DATA_W-1:0] d_out;
    logic              rd_valid;
    logic              empty;
    logic              full;
    logic [PTR_W:0]    count;
    logic              overflow;
    logic              underflow;

    int checks;
    int failures;

    stack_unit #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .tos       (tos),
        .d_in      (d_in),
        .err_clr   (err_clr),
        .d_out     (d_out),
        .rd_valid  (rd_valid),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply one command for one clock, then return strobes to idle.
    task automatic cmd(input logic p_push, input logic p_pop, input logic p_tos,
                       input logic [DATA_W-1:0] p_din, input logic p_clr);
        push    = p_push;
        pop     = p_pop;
        tos     = p_tos;
        d_in    = p_din;
        err_clr = p_clr;
        @(posedge clk);
        #1;
        push    = 1'b0;
        pop     = 1'b0;
        tos     = 1'b0;
        err_clr = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        push     = 1'b0;
        pop      = 1'b0;
        tos      = 1'b0;
        d_in     = '0;
        err_clr  = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", 32'(count), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_dout", 32'(d_out), 0);
        check("rst_rdv", 32'(rd_valid), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_udf", 32'(underflow), 0);
        rst = 1'b1;

        // Push three, pop one.
        cmd(1, 0, 0, 8'h11, 0);
        cmd(1, 0, 0, 8'h22, 0);
        cmd(1, 0, 0, 8'h33, 0);
        check("push3_count", 32'(count), 3);
        cmd(0, 1, 0, 8'h00, 0);
        check("pop_dout", 32'(d_out), 32'h33);
        check("pop_rdv", 32'(rd_valid), 1);
        check("pop_count", 32'(count), 2);
        cmd(0, 0, 0, 8'h00, 0);
        check("idle_rdv", 32'(rd_valid), 0);
        check("idle_dout_hold", 32'(d_out), 32'h33);

        // Peek, then pop returns the same word.
        cmd(0, 0, 1, 8'h00, 0);
        check("tos_dout", 32'(d_out), 32'h22);
        check("tos_rdv", 32'(rd_valid), 1);
        check("tos_count", 32'(count), 2);
        cmd(0, 1, 0, 8'h00, 0);
        check("pop_after_tos", 32'(d_out), 32'h22);
        check("pop_after_tos_cnt", 32'(count), 1);
        cmd(0, 1, 1, 8'h00, 0);   // pop+tos acts as pop
        check("poptos_dout", 32'(d_out), 32'h11);
        check("poptos_count", 32'(count), 0);

        // Pop on empty.
        cmd(0, 1, 0, 8'h00, 0);
        check("udf_dout", 32'(d_out), 0);
        check("udf_rdv", 32'(rd_valid), 0);
        check("udf_flag", 32'(underflow), 1);
        check("udf_count", 32'(count), 0);
        cmd(1, 0, 0, 8'h5A, 0);
        check("push5a_count", 32'(count), 1);
        cmd(0, 0, 1, 8'h00, 0);
        check("tos_5a", 32'(d_out), 32'h5A);
        check("udf_sticky", 32'(underflow), 1);
        cmd(0, 0, 0, 8'h00, 1);
        check("udf_clr", 32'(underflow), 0);
        cmd(0, 1, 0, 8'h00, 0);
        check("pop_5a_count", 32'(count), 0);

        // Fill to DEPTH, then overflow.
        for (int i = 0; i < DEPTH; i++) cmd(1, 0, 0, DATA_W'(i), 0);
        check("fill_full", 32'(full), 1);
        check("fill_count", 32'(count), DEPTH);
        check("fill_no_ovf", 32'(overflow), 0);
        cmd(1, 0, 0, 8'hAA, 0);
        check("ovf_flag", 32'(overflow), 1);
        check("ovf_count", 32'(count), DEPTH);
        check("ovf_full", 32'(full), 1);
        cmd(0, 1, 0, 8'h00, 0);
        check("ovf_pop_dout", 32'(d_out), 32'h0F);
        check("ovf_pop_count", 32'(count), 15);
        cmd(0, 0, 0, 8'h00, 1);
        check("ovf_clr", 32'(overflow), 0);

        // Replace top while full: no overflow.
        cmd(1, 0, 0, 8'h22, 0);
        check("refill_full", 32'(full), 1);
        cmd(1, 1, 0, 8'h77, 0);
        check("rep_dout", 32'(d_out), 32'h22);
        check("rep_count", 32'(count), DEPTH);
        check("rep_no_ovf", 32'(overflow), 0);
        check("rep_rdv", 32'(rd_valid), 1);
        cmd(0, 0, 1, 8'h00, 0);
        check("rep_tos", 32'(d_out), 32'h77);

        // push+tos while full: old top read, push overflows.
        cmd(1, 0, 1, 8'hBB, 0);
        check("pt_dout", 32'(d_out), 32'h77);
        check("pt_ovf", 32'(overflow), 1);
        check("pt_count", 32'(count), DEPTH);
        // err_clr together with a new violation: set wins.
        cmd(1, 0, 0, 8'hCC, 1);
        check("clr_vs_set", 32'(overflow), 1);
        cmd(0, 0, 0, 8'h00, 1);
        check("clr_after", 32'(overflow), 0);

        // Empty the stack, then push+pop on empty.
        for (int i = 0; i < DEPTH; i++) cmd(0, 1, 0, 8'h00, 0);
        check("drain_empty", 32'(empty), 1);
        check("drain_last", 32'(d_out), 32'h00);
        cmd(1, 1, 0, 8'h66, 0);
        check("pp_empty_udf", 32'(underflow), 1);
        check("pp_empty_dout", 32'(d_out), 0);
        check("pp_empty_rdv", 32'(rd_valid), 0);
        check("pp_empty_count", 32'(count), 1);
        cmd(0, 0, 1, 8'h00, 0);
        check("pp_empty_tos", 32'(d_out), 32'h66);

        // Build count=5, d_out=44, underflow=1, then async reset mid-cycle.
        for (int i = 0; i < 4; i++) cmd(1, 0, 0, DATA_W'(8'h40 + i), 0);
        cmd(1, 0, 0, 8'h44, 0);
        cmd(0, 0, 1, 8'h00, 0);
        check("pre_rst_count", 32'(count), 6);
        cmd(0, 1, 0, 8'h00, 0);
        check("pre_rst_dout", 32'(d_out), 32'h44);
        check("pre_rst_cnt5", 32'(count), 5);
        check("pre_rst_udf", 32'(underflow), 1);
        #2;
        rst = 1'b0;
        #1;
        check("arst_count", 32'(count), 0);
        check("arst_dout", 32'(d_out), 0);
        check("arst_udf", 32'(underflow), 0);
        check("arst_empty", 32'(empty), 1);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        cmd(1, 0, 0, 8'h99, 0);
        check("resume_count", 32'(count), 1);
        cmd(0, 1, 0, 8'h00, 0);
        check("resume_dout", 32'(d_out), 32'h99);
        check("resume_rdv", 32'(rd_valid), 1);
        check("resume_empty", 32'(empty), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
